// File: rtl/mul_post_stage_if.sv
// Handshake and data bundle between the lane multiplier, the post stage and writeback.
// slave is the post-stage view; master is the driver/consumer view.
interface mul_post_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      valid_i;
    logic                      ready_o;
    logic [2*DATA_WIDTH-1:0]   product_i;
    logic [2:0]                op_i;
    logic [DATA_WIDTH-1:0]     acc_i;
    logic                      mul_en_o;
    logic                      valid_o;
    logic                      ready_i;
    logic [DATA_WIDTH-1:0]     result_o;
    logic                      vxsat_o;

    modport slave (
        input  valid_i, product_i, op_i, acc_i, ready_i,
        output ready_o, mul_en_o, valid_o, result_o, vxsat_o
    );

    modport master (
        output valid_i, product_i, op_i, acc_i, ready_i,
        input  ready_o, mul_en_o, valid_o, result_o, vxsat_o
    );
endinterface

// File: rtl/mul_post_stage.sv
// Two-stage post-processing of the lane multiplier product: LO/HI select, MACC/NMSAC, SMUL round+saturate.
// Two cycles accept-to-valid, one item per cycle; ready_o drops only when both stages are full and stalled.
module mul_post_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic              module_clk_i,
    input  logic              module_rst_i,
    mul_post_stage_if.slave   bus
);
    localparam int W = DATA_WIDTH;

    localparam logic [2:0] OP_LO    = 3'b000;
    localparam logic [2:0] OP_HI    = 3'b001;
    localparam logic [2:0] OP_MACC  = 3'b010;
    localparam logic [2:0] OP_NMSAC = 3'b011;
    localparam logic [2:0] OP_SMUL  = 3'b100;

    logic             s1_valid;
    logic [2*W-1:0]   s1_product;
    logic [2:0]       s1_op;
    logic [W-1:0]     s1_acc;

    logic             valid_q;
    logic [W-1:0]     result_q;
    logic             vxsat_q;

    logic             s2_free;
    logic             ready;
    logic             accept;

    logic [W-1:0]     lo;
    logic [W-1:0]     hi;
    logic [W-1:0]     smul_rnd;
    logic             smul_sat;
    logic [W-1:0]     nxt_result;
    logic             nxt_vxsat;

    assign s2_free = !valid_q || bus.ready_i;
    assign ready   = !module_rst_i && (!s1_valid || s2_free);
    assign accept  = bus.valid_i && ready;

    assign bus.ready_o  = ready;
    assign bus.mul_en_o = accept;
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;
    assign bus.vxsat_o  = vxsat_q;

    assign lo = s1_product[W-1:0];
    assign hi = s1_product[2*W-1:W];

    // Q(W-1) fractional product: drop the duplicated sign bit and round half up on bit W-2.
    assign smul_rnd = s1_product[2*W-2:W-1] + {{(W-1){1'b0}}, s1_product[W-2]};
    assign smul_sat = (s1_product[2*W-1:2*W-2] == 2'b01);

    always_comb begin
        nxt_result = '0;
        nxt_vxsat  = 1'b0;
        case (s1_op)
            OP_LO:    nxt_result = lo;
            OP_HI:    nxt_result = hi;
            OP_MACC:  nxt_result = s1_acc + lo;
            OP_NMSAC: nxt_result = s1_acc - lo;
            OP_SMUL: begin
                if (smul_sat) begin
                    nxt_result = {1'b0, {(W-1){1'b1}}};
                    nxt_vxsat  = 1'b1;
                end else begin
                    nxt_result = smul_rnd;
                end
            end
            default: begin
                nxt_result = '0;
                nxt_vxsat  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge module_clk_i or posedge module_rst_i) begin
        if (module_rst_i) begin
            s1_valid   <= 1'b0;
            s1_product <= '0;
            s1_op      <= '0;
            s1_acc     <= '0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_product <= bus.product_i;
            s1_op      <= bus.op_i;
            s1_acc     <= bus.acc_i;
        end else if (s2_free) begin
            s1_valid   <= 1'b0;
        end
    end

    // Result registers only change when a real item moves in, so they never show stale S1 data.
    always_ff @(posedge module_clk_i or posedge module_rst_i) begin
        if (module_rst_i) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            vxsat_q  <= 1'b0;
        end else if (s2_free) begin
            valid_q <= s1_valid;
            if (s1_valid) begin
                result_q <= nxt_result;
                vxsat_q  <= nxt_vxsat;
            end
        end
    end
endmodule

// File: doc/mul_post_stage.md
Name: mul_post_stage

Overview:
- Two-stage registered post-processing pipeline that sits directly downstream of the lane multiplier (SYN_MUL).
- Captures the full 2*DATA_WIDTH product and the matching operation/accumulator side-band.
- Applies half-select, multiply-accumulate or fixed-point rounding/saturation, and presents a DATA_WIDTH lane result with a valid/ready handshake.
- Drives the multiplier clock-gate enable so the multiplier toggles only on accepted operations.

Parameters:
- DATA_WIDTH, 32, lane element width; product width is 2*DATA_WIDTH.

Ports:
- module_clk_i  input  1  lane clock.
- module_rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  product_i/op_i/acc_i valid this cycle.
- ready_o  output  1  stage 1 can accept this cycle.
- product_i  input  2*DATA_WIDTH  multiplier product, combinational from the multiplier in the same cycle.
- op_i  input  3  post-op: 000 LO, 001 HI, 010 MACC, 011 NMSAC, 100 SMUL; others reserved.
- acc_i  input  DATA_WIDTH  old destination element for MACC/NMSAC.
- mul_en_o  output  1  multiplier clock-gate enable; equals valid_i & ready_o, combinational.
- valid_o  output  1  result_o/vxsat_o valid.
- ready_i  input  1  downstream (writeback) accepts.
- result_o  output  DATA_WIDTH  lane result.
- vxsat_o  output  1  saturation occurred for this result; qualified by valid_o.

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-high on module_rst_i.
- While reset is asserted, all registers clear:
  - valid_o=0, result_o=0, vxsat_o=0;
  - internal s1_valid=0, s1 product/op/acc=0;
  - ready_o therefore reads 1 only after reset deasserts. It is forced to 0 while module_rst_i=1, so mul_en_o=0 during reset.
- Reset mid-operation discards all in-flight items; nothing is replayed.
- Stage 1 (S1) registers product_i, op_i, acc_i and sets s1_valid on accept = valid_i & ready_o.
- Stage 2 (S2) computes from the S1 registers and loads result_o/vxsat_o/valid_o.
- Advance and ready rules:
  - s2_free = !valid_o | ready_i.
  - ready_o = !s1_valid | s2_free.
  - When s2_free: valid_o <= s1_valid, and result/vxsat load from S1.
  - S1 loads on accept. Otherwise s1_valid clears when S1 moves into S2.
- Latency: accept at cycle N gives valid_o at N+2 with no stall. Throughput is one item per cycle; back-to-back accept with ready_i=1 is continuous.
- Stall: while valid_o=1 and ready_i=0, result_o/vxsat_o/valid_o hold stable. With S1 also full, ready_o=0 and mul_en_o=0.
- Simultaneous accept and S1 drain in the same cycle is legal; S1 takes the new item.
- Arithmetic (P = S1 product, LO = P[W-1:0], HI = P[2W-1:W], W = DATA_WIDTH):
  - LO: result = LO.
  - HI: result = HI. Signedness is set upstream by the multiplier tc_i.
  - MACC: result = (acc + LO) mod 2^W.
  - NMSAC: result = (acc - LO) mod 2^W.
  - SMUL (signed fractional, round-to-nearest-up, requires tc_i=1 upstream):
    - t = P[2W-2:W-1] + P[W-2], computed at W+1 bits.
    - If P[2W-1:2W-2] == 2'b01, i.e. operands both most-negative: result = 2^(W-1)-1 and vxsat=1.
    - Otherwise result = t[W-1:0] and vxsat=0.
  - Reserved op: result=0, vxsat=0; valid still flows.
- vxsat_o is a per-result flag, not sticky. It is 0 for all ops except saturated SMUL.
- No X propagation: S1 data registers load only on accept, which keeps them stable for the clock-gating power intent.

Test Plan:
- Reset: assert module_rst_i mid-stream with 2 items in flight -> valid_o=0, result_o=0, ready_o=0 during reset. After release ready_o=1 and no stale result appears.
- LO/HI: product 0xFFFFFFFF_00000001 with op LO, then op HI, ready_i=1 -> result_o 0x00000001 at N+2, then 0xFFFFFFFF at N+3, vxsat_o=0.
- MACC/NMSAC:
  - acc=10, LO=6, op MACC -> 16.
  - acc=10, LO=12, op NMSAC -> 0xFFFFFFFE.
  - acc=0xFFFFFFFF, LO=1, op MACC -> 0x00000000 (wrap).
- SMUL:
  - product 0x10000000_00000000 -> 0x20000000, vxsat 0.
  - product 0x00000000_C0000000 -> 0x00000002 (round up), vxsat 0.
  - product 0x40000000_00000000 -> 0x7FFFFFFF, vxsat_o=1.
- Backpressure: stream 4 items with ready_i=0 for 3 cycles -> ready_o drops after 2 accepts, mul_en_o=0 while stalled, result_o stable. On ready_i=1 all 4 results emerge in order, none lost or duplicated.
- Throughput/reserved: 8 back-to-back valid_i with ready_i=1 -> 8 consecutive valid_o cycles. A reserved op (3'b111) in the stream yields result 0 in its slot.
